// File: rtl/converter_arbiter_pkg.sv
// Shared types for the converter arbiter: word width, pipeline tag, requester ids
// and the round-robin priority state.
package converter_arbiter_pkg;

  function automatic int unsigned word_width(input int unsigned montissa_length);
    return montissa_length + 9;
  endfunction

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_id_e;

  typedef enum logic {
    PRIO_REQ0 = 1'b0,
    PRIO_REQ1 = 1'b1
  } rr_state_e;

  typedef struct packed {
    logic    valid;
    req_id_e id;
  } tag_t;

  localparam tag_t TAG_IDLE = '{valid: 1'b0, id: REQ0};

endpackage

// File: rtl/converter_arbiter_if.sv
// Request, response and converter-pipeline signals of the converter arbiter.
interface converter_arbiter_if
  import converter_arbiter_pkg::*;
#(
  parameter int unsigned montissa_length = 23
);
  localparam int unsigned W = word_width(montissa_length);

  logic         req0_valid;
  logic         req0_ready;
  logic [W-1:0] req0_data;
  logic         req1_valid;
  logic         req1_ready;
  logic [W-1:0] req1_data;
  logic         pipe_in_valid;
  logic [W-1:0] pipe_in_data;
  logic [W-1:0] pipe_out_data;
  logic         rsp0_valid;
  logic         rsp0_ready;
  logic [W-1:0] rsp0_data;
  logic         rsp1_valid;
  logic         rsp1_ready;
  logic [W-1:0] rsp1_data;

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data,
    input  rsp0_ready, rsp1_ready, pipe_out_data,
    output req0_ready, req1_ready, pipe_in_valid, pipe_in_data,
    output rsp0_valid, rsp0_data, rsp1_valid, rsp1_data
  );

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data,
    output rsp0_ready, rsp1_ready, pipe_out_data,
    input  req0_ready, req1_ready, pipe_in_valid, pipe_in_data,
    input  rsp0_valid, rsp0_data, rsp1_valid, rsp1_data
  );

endinterface

// File: rtl/conv_rsp_fifo.sv
// Per-requester response FIFO; push and pop may coincide at any occupancy.
module conv_rsp_fifo #(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [W-1:0]                 wr_data,
  input  logic                         rd_ready,
  output logic                         rd_valid,
  output logic [W-1:0]                 rd_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          pop;

  assign rd_valid = (count != '0);
  assign pop      = rd_valid && rd_ready;
  assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/customized_delay.sv
// One register stage of the converter pipeline model.
module customized_delay #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else        q <= d;
  end

endmodule

// File: rtl/converter_arbiter.sv
// Round-robin arbiter sharing one fixed-latency converter between two requesters,
// with credit-based flow control into per-requester response FIFOs.
module converter_arbiter
  import converter_arbiter_pkg::*;
#(
  parameter int unsigned montissa_length = 23,
  parameter int unsigned PIPE_LATENCY    = 1,
  parameter int unsigned RSP_DEPTH       = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  converter_arbiter_if.slave  bus
);
  localparam int unsigned W         = word_width(montissa_length);
  localparam int unsigned CW        = $clog2(RSP_DEPTH + 1);
  localparam logic [CW:0] DEPTH_LIM = (CW + 1)'(RSP_DEPTH);

  tag_t          tag_sr [PIPE_LATENCY];
  tag_t          tag_in;
  tag_t          tag_out;
  rr_state_e     rr_q;
  rr_state_e     rr_d;
  logic [CW-1:0] inflight [2];
  logic [CW-1:0] count [2];
  logic [1:0]    credit;
  logic [1:0]    elig;
  logic [1:0]    grant;
  logic [1:0]    wr_en;
  logic          launch;

  // A slot is reserved at launch, so FIFO space is guaranteed when the tag exits.
  always_comb begin
    credit = '0;
    for (int unsigned i = 0; i < 2; i++)
      credit[i] = ({1'b0, count[i]} + {1'b0, inflight[i]}) < DEPTH_LIM;
  end

  always_comb begin
    elig  = {bus.req1_valid, bus.req0_valid} & credit & {2{rst_n}};
    grant = '0;
    rr_d  = rr_q;
    if (elig[0] && (!elig[1] || rr_q == PRIO_REQ0)) begin
      grant[0] = 1'b1;
      rr_d     = PRIO_REQ1;
    end else if (elig[1]) begin
      grant[1] = 1'b1;
      rr_d     = PRIO_REQ0;
    end
  end

  assign launch            = |grant;
  assign bus.req0_ready    = grant[0];
  assign bus.req1_ready    = grant[1];
  assign bus.pipe_in_valid = launch;
  assign bus.pipe_in_data  = grant[0] ? bus.req0_data :
                             grant[1] ? bus.req1_data : '0;

  always_comb begin
    tag_in       = TAG_IDLE;
    tag_in.valid = launch;
    tag_in.id    = grant[1] ? REQ1 : REQ0;
  end

  assign tag_out  = tag_sr[PIPE_LATENCY-1];
  assign wr_en[0] = tag_out.valid && (tag_out.id == REQ0);
  assign wr_en[1] = tag_out.valid && (tag_out.id == REQ1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_q <= PRIO_REQ0;
    else        rr_q <= rr_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < PIPE_LATENCY; k++) tag_sr[k] <= TAG_IDLE;
    end else begin
      tag_sr[0] <= tag_in;
      for (int unsigned k = 1; k < PIPE_LATENCY; k++) tag_sr[k] <= tag_sr[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 2; i++) inflight[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (grant[i] && !wr_en[i])      inflight[i] <= inflight[i] + 1'b1;
        else if (!grant[i] && wr_en[i]) inflight[i] <= inflight[i] - 1'b1;
      end
    end
  end

  conv_rsp_fifo #(.W(W), .DEPTH(RSP_DEPTH)) u_rsp_fifo0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en[0]),
    .wr_data  (bus.pipe_out_data),
    .rd_ready (bus.rsp0_ready),
    .rd_valid (bus.rsp0_valid),
    .rd_data  (bus.rsp0_data),
    .count    (count[0])
  );

  conv_rsp_fifo #(.W(W), .DEPTH(RSP_DEPTH)) u_rsp_fifo1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en[1]),
    .wr_data  (bus.pipe_out_data),
    .rd_ready (bus.rsp1_ready),
    .rd_valid (bus.rsp1_valid),
    .rd_data  (bus.rsp1_data),
    .count    (count[1])
  );

endmodule

// File: tb/tb_converter_arbiter.sv
// Bench for converter_arbiter: a latency-1 and a latency-8 instance share stimulus
// and are compared against a queue-based model of the credit/round-robin rules.
module tb_converter_arbiter;
  import converter_arbiter_pkg::*;

  localparam int unsigned M     = 23;
  localparam int unsigned W     = word_width(M);
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LAT_A = 1;
  localparam int unsigned LAT_B = 8;

  typedef struct packed {
    logic [W-1:0] data;
    logic [31:0]  due;
  } item_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         r_valid [2];
  logic [W-1:0] r_data  [2];
  logic         s_ready [2];

  converter_arbiter_if #(.montissa_length(M)) bus_a ();
  converter_arbiter_if #(.montissa_length(M)) bus_b ();

  assign bus_a.req0_valid = r_valid[0];
  assign bus_a.req0_data  = r_data[0];
  assign bus_a.req1_valid = r_valid[1];
  assign bus_a.req1_data  = r_data[1];
  assign bus_a.rsp0_ready = s_ready[0];
  assign bus_a.rsp1_ready = s_ready[1];
  assign bus_b.req0_valid = r_valid[0];
  assign bus_b.req0_data  = r_data[0];
  assign bus_b.req1_valid = r_valid[1];
  assign bus_b.req1_data  = r_data[1];
  assign bus_b.rsp0_ready = s_ready[0];
  assign bus_b.rsp1_ready = s_ready[1];

  // Delay stages are never reset so stale words keep flowing across a reset.
  logic [W-1:0] chain_a [LAT_A+1];
  logic [W-1:0] chain_b [LAT_B+1];
  assign chain_a[0] = bus_a.pipe_in_data;
  assign chain_b[0] = bus_b.pipe_in_data;
  for (genvar s = 0; s < LAT_A; s++) begin : g_da
    customized_delay #(.W(W)) u_d (.clk(clk), .rst_n(1'b1), .d(chain_a[s]), .q(chain_a[s+1]));
  end
  for (genvar s = 0; s < LAT_B; s++) begin : g_db
    customized_delay #(.W(W)) u_d (.clk(clk), .rst_n(1'b1), .d(chain_b[s]), .q(chain_b[s+1]));
  end
  assign bus_a.pipe_out_data = chain_a[LAT_A];
  assign bus_b.pipe_out_data = chain_b[LAT_B];

  converter_arbiter #(.montissa_length(M), .PIPE_LATENCY(LAT_A), .RSP_DEPTH(DEPTH)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a));
  converter_arbiter #(.montissa_length(M), .PIPE_LATENCY(LAT_B), .RSP_DEPTH(DEPTH)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b));

  logic         o_rdy [2][2];
  logic         o_rv  [2][2];
  logic [W-1:0] o_rd  [2][2];
  logic         o_pv  [2];
  logic [W-1:0] o_pd  [2];
  assign o_rdy[0][0] = bus_a.req0_ready;  assign o_rdy[0][1] = bus_a.req1_ready;
  assign o_rdy[1][0] = bus_b.req0_ready;  assign o_rdy[1][1] = bus_b.req1_ready;
  assign o_rv[0][0]  = bus_a.rsp0_valid;  assign o_rv[0][1]  = bus_a.rsp1_valid;
  assign o_rv[1][0]  = bus_b.rsp0_valid;  assign o_rv[1][1]  = bus_b.rsp1_valid;
  assign o_rd[0][0]  = bus_a.rsp0_data;   assign o_rd[0][1]  = bus_a.rsp1_data;
  assign o_rd[1][0]  = bus_b.rsp0_data;   assign o_rd[1][1]  = bus_b.rsp1_data;
  assign o_pv[0]     = bus_a.pipe_in_valid;
  assign o_pv[1]     = bus_b.pipe_in_valid;
  assign o_pd[0]     = bus_a.pipe_in_data;
  assign o_pd[1]     = bus_b.pipe_in_data;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: each queue holds results owed to one requester of one instance, with the
  // cycle at which that result becomes visible. Outstanding count = queue size.
  item_t        mq [4][$];
  int           last_grant [2];
  int           exp_grant  [2];
  int unsigned  cyc;
  logic         exp_rdy [2][2];
  logic         exp_rv  [2][2];
  logic [W-1:0] exp_rd  [2][2];
  logic         exp_pv  [2];
  logic [W-1:0] exp_pd  [2];

  function automatic int unsigned lat_of(input int i);
    return (i == 0) ? LAT_A : LAT_B;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) mq[k].delete();
    last_grant[0] = 1;
    last_grant[1] = 1;
  endtask

  task automatic model_expect();
    for (int i = 0; i < 2; i++) begin
      logic e0, e1;
      e0 = rst_n && r_valid[0] && (mq[i*2].size() < DEPTH);
      e1 = rst_n && r_valid[1] && (mq[i*2+1].size() < DEPTH);
      if (e0 && e1)  exp_grant[i] = (last_grant[i] == 0) ? 1 : 0;
      else if (e0)   exp_grant[i] = 0;
      else if (e1)   exp_grant[i] = 1;
      else           exp_grant[i] = -1;
      exp_pv[i] = (exp_grant[i] >= 0);
      exp_pd[i] = (exp_grant[i] >= 0) ? r_data[exp_grant[i]] : '0;
      for (int r = 0; r < 2; r++) begin
        exp_rdy[i][r] = (exp_grant[i] == r);
        exp_rv[i][r]  = rst_n && (mq[i*2+r].size() > 0) && (mq[i*2+r][0].due <= cyc);
        exp_rd[i][r]  = exp_rv[i][r] ? mq[i*2+r][0].data : '0;
      end
    end
  endtask

  task automatic model_commit();
    for (int i = 0; i < 2; i++) begin
      if (exp_grant[i] >= 0) begin
        mq[i*2+exp_grant[i]].push_back('{data: r_data[exp_grant[i]], due: cyc + lat_of(i) + 1});
        last_grant[i] = exp_grant[i];
      end
      for (int r = 0; r < 2; r++)
        if (exp_rv[i][r] && s_ready[r]) void'(mq[i*2+r].pop_front());
    end
    cyc++;
  endtask

  task automatic settle();
    @(negedge clk);
    model_expect();
  endtask

  task automatic advance();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    for (int r = 0; r < 2; r++) begin
      r_valid[r] = 1'b1;
      r_data[r]  = $urandom();
      s_ready[r] = 1'b1;
    end
    repeat (2) begin
      settle();
      for (int i = 0; i < 2; i++) begin
        for (int r = 0; r < 2; r++) begin
          n_checks++;
          if (o_rdy[i][r] !== 1'b0 || o_rv[i][r] !== 1'b0 || o_rd[i][r] !== '0) begin
            n_fail++;
            $display("FAIL reset_out inst%0d port%0d got rdy=%b rv=%b rd=%h exp 0/0/0",
                     i, r, o_rdy[i][r], o_rv[i][r], o_rd[i][r]);
          end
        end
        n_checks++;
        if (o_pv[i] !== 1'b0 || o_pd[i] !== '0) begin
          n_fail++;
          $display("FAIL reset_pipe inst%0d got pv=%b pd=%h exp 0/0", i, o_pv[i], o_pd[i]);
        end
      end
      advance();
    end
    r_valid[0] = 1'b0;
    r_valid[1] = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    r_valid[0] = 1'b1;
    r_data[0]  = 32'h3F80_0000;
    settle();
    n_checks++;
    if (o_rdy[0][0] !== 1'b1 || o_pv[0] !== 1'b1 || o_pd[0] !== 32'h3F80_0000) begin
      n_fail++;
      $display("FAIL single_launch got rdy=%b pv=%b pd=%h exp 1/1/3f800000", o_rdy[0][0], o_pv[0], o_pd[0]);
    end
    advance();
    r_valid[0] = 1'b0;
    settle();
    n_checks++;
    if (o_rv[0][0] !== 1'b0) begin
      n_fail++;
      $display("FAIL single_early got rv=%b exp 0", o_rv[0][0]);
    end
    advance();
    settle();
    n_checks++;
    if (o_rv[0][0] !== 1'b1 || o_rd[0][0] !== 32'h3F80_0000) begin
      n_fail++;
      $display("FAIL single_rsp got rv=%b rd=%h exp 1/3f800000", o_rv[0][0], o_rd[0][0]);
    end
    advance();
    repeat (9) begin
      settle();
      n_checks++;
      if (o_rv[1][0] !== exp_rv[1][0] || o_rd[1][0] !== exp_rd[1][0]) begin
        n_fail++;
        $display("FAIL single_rsp_lat8 got rv=%b rd=%h exp rv=%b rd=%h",
                 o_rv[1][0], o_rd[1][0], exp_rv[1][0], exp_rd[1][0]);
      end
      advance();
    end
  endtask

  task automatic test_alternate();
    int prev_g = -1;
    int g;
    r_valid[0] = 1'b1;
    r_valid[1] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (k == 8) begin
        r_valid[0] = 1'b0;
        r_valid[1] = 1'b0;
      end
      r_data[0] = $urandom();
      r_data[1] = $urandom();
      settle();
      if (k < 8) begin
        g = o_rdy[0][1] ? 1 : 0;
        n_checks++;
        if ((o_rdy[0][0] ^ o_rdy[0][1]) !== 1'b1 || (prev_g >= 0 && g == prev_g)) begin
          n_fail++;
          $display("FAIL alt_grant cycle%0d got rdy0=%b rdy1=%b prev=%0d exp one grant != prev",
                   k, o_rdy[0][0], o_rdy[0][1], prev_g);
        end
        prev_g = g;
      end
      for (int i = 0; i < 2; i++) begin
        for (int r = 0; r < 2; r++) begin
          n_checks++;
          if (o_rdy[i][r] !== exp_rdy[i][r] || o_rv[i][r] !== exp_rv[i][r] || o_rd[i][r] !== exp_rd[i][r]) begin
            n_fail++;
            $display("FAIL alt_model inst%0d port%0d got rdy=%b rv=%b rd=%h exp rdy=%b rv=%b rd=%h",
                     i, r, o_rdy[i][r], o_rv[i][r], o_rd[i][r], exp_rdy[i][r], exp_rv[i][r], exp_rd[i][r]);
          end
        end
      end
      advance();
    end
  endtask

  task automatic test_backpressure();
    int acc0 = 0;
    int late1 = 0;
    s_ready[0] = 1'b0;
    s_ready[1] = 1'b1;
    r_valid[0] = 1'b1;
    r_valid[1] = 1'b1;
    for (int k = 0; k < 16; k++) begin
      settle();
      if (o_rdy[0][0] === 1'b1) acc0++;
      if (k >= 8 && o_rdy[0][1] === 1'b1) late1++;
      for (int i = 0; i < 2; i++) begin
        for (int r = 0; r < 2; r++) begin
          n_checks++;
          if (o_rdy[i][r] !== exp_rdy[i][r] || o_rv[i][r] !== exp_rv[i][r] || o_rd[i][r] !== exp_rd[i][r]) begin
            n_fail++;
            $display("FAIL bp_model inst%0d port%0d got rdy=%b rv=%b rd=%h exp rdy=%b rv=%b rd=%h",
                     i, r, o_rdy[i][r], o_rv[i][r], o_rd[i][r], exp_rdy[i][r], exp_rv[i][r], exp_rd[i][r]);
          end
        end
      end
      advance();
      r_data[0] = $urandom();
      r_data[1] = $urandom();
    end
    settle();
    n_checks++;
    if (acc0 != 4 || o_rdy[0][0] !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_credit got accepted=%0d rdy0=%b exp 4/0", acc0, o_rdy[0][0]);
    end
    n_checks++;
    if (late1 != 8) begin
      n_fail++;
      $display("FAIL bp_other_rate got req1 grants=%0d exp 8", late1);
    end
    advance();
  endtask

  task automatic test_full_pop();
    s_ready[0] = 1'b1;
    r_valid[1] = 1'b0;
    for (int k = 0; k < 28; k++) begin
      r_valid[0] = (k < 14);
      r_data[0]  = $urandom();
      settle();
      for (int i = 0; i < 2; i++) begin
        for (int r = 0; r < 2; r++) begin
          n_checks++;
          if (o_rdy[i][r] !== exp_rdy[i][r] || o_rv[i][r] !== exp_rv[i][r] || o_rd[i][r] !== exp_rd[i][r]) begin
            n_fail++;
            $display("FAIL fullpop_model inst%0d port%0d got rdy=%b rv=%b rd=%h exp rdy=%b rv=%b rd=%h",
                     i, r, o_rdy[i][r], o_rv[i][r], o_rd[i][r], exp_rdy[i][r], exp_rv[i][r], exp_rd[i][r]);
          end
        end
      end
      advance();
    end
  endtask

  task automatic test_reset_midflight();
    s_ready[0] = 1'b0;
    s_ready[1] = 1'b0;
    r_valid[0] = 1'b1;
    r_valid[1] = 1'b1;
    repeat (3) begin
      r_data[0] = $urandom();
      r_data[1] = $urandom();
      settle();
      advance();
    end
    rst_n = 1'b0;
    model_reset();
    r_valid[0] = 1'b0;
    r_valid[1] = 1'b0;
    settle();
    for (int i = 0; i < 2; i++) begin
      for (int r = 0; r < 2; r++) begin
        n_checks++;
        if (o_rv[i][r] !== 1'b0 || o_rd[i][r] !== '0 || o_rdy[i][r] !== 1'b0) begin
          n_fail++;
          $display("FAIL midrst_out inst%0d port%0d got rv=%b rd=%h rdy=%b exp 0/0/0",
                   i, r, o_rv[i][r], o_rd[i][r], o_rdy[i][r]);
        end
      end
    end
    advance();
    rst_n = 1'b1;
    s_ready[0] = 1'b1;
    s_ready[1] = 1'b1;
    repeat (12) begin
      settle();
      for (int i = 0; i < 2; i++) begin
        for (int r = 0; r < 2; r++) begin
          n_checks++;
          if (o_rv[i][r] !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_stale inst%0d port%0d got rv=%b rd=%h exp rv=0", i, r, o_rv[i][r], o_rd[i][r]);
          end
        end
      end
      advance();
    end
    r_valid[1] = 1'b1;
    r_data[1]  = $urandom();
    for (int k = 0; k < 12; k++) begin
      settle();
      for (int i = 0; i < 2; i++) begin
        for (int r = 0; r < 2; r++) begin
          n_checks++;
          if (o_rdy[i][r] !== exp_rdy[i][r] || o_rv[i][r] !== exp_rv[i][r] || o_rd[i][r] !== exp_rd[i][r]) begin
            n_fail++;
            $display("FAIL midrst_next inst%0d port%0d got rdy=%b rv=%b rd=%h exp rdy=%b rv=%b rd=%h",
                     i, r, o_rdy[i][r], o_rv[i][r], o_rd[i][r], exp_rdy[i][r], exp_rv[i][r], exp_rd[i][r]);
          end
        end
      end
      advance();
      r_valid[1] = 1'b0;
    end
  endtask

  task automatic test_random();
    logic mode [2];
    mode[0] = 1'b1;
    mode[1] = 1'b1;
    for (int n = 0; n < 10030; n++) begin
      for (int r = 0; r < 2; r++) begin
        if ($urandom_range(0, 49) == 0) mode[r] = !mode[r];
        r_valid[r] = (n < 10000) && ($urandom_range(0, 99) < 70);
        r_data[r]  = $urandom();
        s_ready[r] = (n >= 10000) ? 1'b1 :
                     mode[r] ? ($urandom_range(0, 99) < 85) : ($urandom_range(0, 99) < 10);
      end
      settle();
      for (int i = 0; i < 2; i++) begin
        n_checks++;
        if (o_pv[i] !== exp_pv[i] || o_pd[i] !== exp_pd[i]) begin
          n_fail++;
          $display("FAIL rand_pipe n=%0d inst%0d got pv=%b pd=%h exp pv=%b pd=%h",
                   n, i, o_pv[i], o_pd[i], exp_pv[i], exp_pd[i]);
        end
        for (int r = 0; r < 2; r++) begin
          n_checks++;
          if (o_rdy[i][r] !== exp_rdy[i][r] || o_rv[i][r] !== exp_rv[i][r] || o_rd[i][r] !== exp_rd[i][r]) begin
            n_fail++;
            $display("FAIL rand_model n=%0d inst%0d port%0d got rdy=%b rv=%b rd=%h exp rdy=%b rv=%b rd=%h",
                     n, i, r, o_rdy[i][r], o_rv[i][r], o_rd[i][r], exp_rdy[i][r], exp_rv[i][r], exp_rd[i][r]);
          end
        end
      end
      advance();
      if (n_fail > 40) break;
    end
    settle();
    for (int i = 0; i < 2; i++) begin
      for (int r = 0; r < 2; r++) begin
        n_checks++;
        if (o_rv[i][r] !== 1'b0 || mq[i*2+r].size() != 0) begin
          n_fail++;
          $display("FAIL rand_drain inst%0d port%0d got rv=%b owed=%0d exp rv=0 owed=0",
                   i, r, o_rv[i][r], mq[i*2+r].size());
        end
      end
    end
    advance();
  endtask

  initial begin
    rst_n = 1'b0;
    cyc   = 0;
    for (int r = 0; r < 2; r++) begin
      r_valid[r] = 1'b0;
      r_data[r]  = '0;
      s_ready[r] = 1'b0;
    end
    model_reset();
    test_reset();
    test_single();
    test_alternate();
    test_backpressure();
    test_full_pop();
    test_reset_midflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
